// File: rtl/sd_spi_pkg.sv
// Shared constants, error codes and FSM encoding for the SPI-mode SD
// single-block read/write engine.
package sd_spi_pkg;

    localparam logic [7:0] CMD17     = 8'h51;
    localparam logic [7:0] CMD24     = 8'h58;
    localparam logic [7:0] START_TOK = 8'hFE;
    localparam logic [7:0] IDLE_BYTE = 8'hFF;
    localparam logic [4:0] DATA_ACCEPT = 5'h05;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_R1_TMO   = 3'd1;
    localparam logic [2:0] ERR_R1_BAD   = 3'd2;
    localparam logic [2:0] ERR_TOKEN    = 3'd3;
    localparam logic [2:0] ERR_WR_REJ   = 3'd4;
    localparam logic [2:0] ERR_BUSY_TMO = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE, S_CS_ON, S_CMD, S_R1,
        S_RD_TOK, S_RD_DATA, S_RD_CRC,
        S_WR_GAP, S_WR_TOK, S_WR_DATA, S_WR_CRC, S_WR_RESP, S_WR_BUSY,
        S_FINISH
    } state_t;

    // Byte idx of the 6-byte command frame; the CRC slot is a dummy 0xFF.
    function automatic logic [7:0] cmd_frame_byte(input logic [2:0] idx,
                                                  input logic [7:0] cmd,
                                                  input logic [31:0] arg);
        logic [7:0] b;
        case (idx)
            3'd0:    b = cmd;
            3'd1:    b = arg[31:24];
            3'd2:    b = arg[23:16];
            3'd3:    b = arg[15:8];
            3'd4:    b = arg[7:0];
            default: b = IDLE_BYTE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sd_spi_byte.sv
// SPI mode-0 byte shifter: one byte per start pulse, MSB first,
// 16*CLK_DIV clk cycles per byte, byte_done pulses at the final falling edge.
module sd_spi_byte #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic          active_q, active_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    half_q, half_d;
    logic [7:0]    tx_q, tx_d, rx_q, rx_d;
    logic          sclk_q, sclk_d, mosi_q, mosi_d, done_q, done_d;

    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        half_d   = half_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        done_d   = 1'b0;
        if (start && !active_q) begin
            active_d = 1'b1;
            div_d    = '0;
            half_d   = '0;
            tx_d     = tx_byte;
            mosi_d   = tx_byte[7];
            sclk_d   = 1'b0;
        end else if (active_q) begin
            if (div_q != DIV_LAST) begin
                div_d = div_q + DW'(1);
            end else begin
                div_d  = '0;
                half_d = half_q + 4'd1;
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[6:0], miso};
                end else begin
                    sclk_d = 1'b0;
                    // Last falling edge ends the byte and parks MOSI high.
                    if (half_q == 4'd15) begin
                        active_d = 1'b0;
                        done_d   = 1'b1;
                        mosi_d   = 1'b1;
                    end else begin
                        tx_d   = {tx_q[6:0], 1'b1};
                        mosi_d = tx_q[6];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            div_q    <= '0;
            half_q   <= '0;
            tx_q     <= '1;
            rx_q     <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            half_q   <= half_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            done_q   <= done_d;
        end
    end

    assign rx_byte   = rx_q;
    assign byte_done = done_q;
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;

endmodule

// File: rtl/sd_spi_block.sv
// Single-block SD read (CMD17) / write (CMD24) over SPI with a shared
// 512-byte sector buffer that the host fills or drains while idle.
module sd_spi_block
    import sd_spi_pkg::*;
#(
    parameter int          CLK_DIV    = 4,
    parameter int          BLOCK_ADDR = 1,
    parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] lba,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [7:0]  wr_data,
    input  logic [8:0]  wr_addr,
    input  logic [8:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  err_code,
    output logic        sd_sclk,
    output logic        sd_mosi,
    input  logic        sd_miso,
    output logic        sd_cs_n
);

    localparam logic [15:0] TMO_LAST = TIMEOUT - 16'd1;

    state_t      state_q, state_d;
    logic [8:0]  idx_q, idx_d;
    logic [15:0] tmo_q, tmo_d;
    logic [31:0] lba_q, lba_d;
    logic        wr_op_q, wr_op_d, inflight_q, inflight_d;
    logic [2:0]  pend_q, pend_d, code_q, code_d;
    logic        done_q, done_d, err_q, err_d, busy_q, busy_d, cs_n_q, cs_n_d;

    logic [7:0]  mem [0:511];
    logic [7:0]  buf_rd_q, rd_data_q;
    logic        mem_we;
    logic [8:0]  mem_waddr;
    logic [7:0]  mem_wdata;

    logic        eng_start, eng_done;
    logic [7:0]  eng_tx, eng_rx;
    logic [31:0] card_arg;

    assign card_arg = (BLOCK_ADDR != 0) ? lba_q : {lba_q[22:0], 9'd0};

    sd_spi_byte #(.CLK_DIV(CLK_DIV)) u_byte (
        .clk(clk), .rst_n(rst_n), .start(eng_start), .tx_byte(eng_tx),
        .rx_byte(eng_rx), .byte_done(eng_done), .sclk(sd_sclk),
        .mosi(sd_mosi), .miso(sd_miso)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tmo_d      = tmo_q;
        lba_d      = lba_q;
        wr_op_d    = wr_op_q;
        inflight_d = inflight_q;
        pend_d     = pend_q;
        code_d     = code_q;
        done_d     = done_q;
        err_d      = err_q;
        eng_start  = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = wr_addr;
        mem_wdata  = wr_data;
        case (state_q)
            S_CMD:     eng_tx = cmd_frame_byte(idx_q[2:0], wr_op_q ? CMD24 : CMD17, card_arg);
            S_WR_TOK:  eng_tx = START_TOK;
            S_WR_DATA: eng_tx = buf_rd_q;
            default:   eng_tx = IDLE_BYTE;
        endcase

        if (state_q == S_IDLE) begin
            // Host owns the write port while idle; a read request beats a commit.
            mem_we = wr_req;
            if (rd_req || (wr_req && wr_addr == 9'd511)) begin
                state_d    = S_CS_ON;
                lba_d      = lba;
                wr_op_d    = !rd_req;
                idx_d      = '0;
                tmo_d      = '0;
                inflight_d = 1'b0;
                pend_d     = ERR_NONE;
                code_d     = ERR_NONE;
                done_d     = 1'b0;
                err_d      = 1'b0;
            end
        end else if (!inflight_q) begin
            eng_start  = 1'b1;
            inflight_d = 1'b1;
        end else if (eng_done) begin
            inflight_d = 1'b0;
            case (state_q)
                S_CS_ON: begin state_d = S_CMD; idx_d = '0; end
                S_CMD: begin
                    if (idx_q == 9'd5) begin state_d = S_R1; idx_d = '0; end
                    else idx_d = idx_q + 9'd1;
                end
                S_R1: begin
                    if (!eng_rx[7]) begin
                        tmo_d = '0;
                        if (eng_rx == 8'h00) state_d = wr_op_q ? S_WR_GAP : S_RD_TOK;
                        else begin state_d = S_FINISH; pend_d = ERR_R1_BAD; end
                    end else if (idx_q == 9'd7) begin
                        state_d = S_FINISH; pend_d = ERR_R1_TMO;
                    end else idx_d = idx_q + 9'd1;
                end
                S_RD_TOK: begin
                    if (eng_rx == START_TOK) begin state_d = S_RD_DATA; idx_d = '0; end
                    else if (eng_rx != IDLE_BYTE || tmo_q >= TMO_LAST) begin
                        state_d = S_FINISH; pend_d = ERR_TOKEN;
                    end else tmo_d = tmo_q + 16'd1;
                end
                S_RD_DATA: begin
                    mem_we    = 1'b1;
                    mem_waddr = idx_q;
                    mem_wdata = eng_rx;
                    if (idx_q == 9'd511) begin state_d = S_RD_CRC; idx_d = '0; end
                    else idx_d = idx_q + 9'd1;
                end
                S_RD_CRC, S_WR_CRC: begin
                    if (idx_q == 9'd1) state_d = (state_q == S_RD_CRC) ? S_FINISH : S_WR_RESP;
                    else idx_d = idx_q + 9'd1;
                end
                S_WR_GAP: state_d = S_WR_TOK;
                S_WR_TOK: begin state_d = S_WR_DATA; idx_d = '0; end
                S_WR_DATA: begin
                    if (idx_q == 9'd511) begin state_d = S_WR_CRC; idx_d = '0; end
                    else idx_d = idx_q + 9'd1;
                end
                S_WR_RESP: begin
                    tmo_d = '0;
                    if (eng_rx[4:0] == DATA_ACCEPT) state_d = S_WR_BUSY;
                    else begin state_d = S_FINISH; pend_d = ERR_WR_REJ; end
                end
                S_WR_BUSY: begin
                    if (eng_rx != 8'h00) state_d = S_FINISH;
                    else if (tmo_q >= TMO_LAST) begin state_d = S_FINISH; pend_d = ERR_BUSY_TMO; end
                    else tmo_d = tmo_q + 16'd1;
                end
                S_FINISH: begin
                    state_d = S_IDLE;
                    done_d  = (pend_q == ERR_NONE);
                    err_d   = (pend_q != ERR_NONE);
                    code_d  = pend_q;
                end
                default: ;
            endcase
        end
        busy_d = (state_d != S_IDLE);
        cs_n_d = (state_d == S_IDLE) || (state_d == S_FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            tmo_q      <= '0;
            lba_q      <= '0;
            wr_op_q    <= 1'b0;
            inflight_q <= 1'b0;
            pend_q     <= ERR_NONE;
            code_q     <= ERR_NONE;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            cs_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tmo_q      <= tmo_d;
            lba_q      <= lba_d;
            wr_op_q    <= wr_op_d;
            inflight_q <= inflight_d;
            pend_q     <= pend_d;
            code_q     <= code_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            cs_n_q     <= cs_n_d;
        end
    end

    // Transmit-side read uses the next index so the byte is ready at start.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        buf_rd_q <= mem[idx_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= mem[rd_addr];
    end

    assign rd_data  = rd_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = code_q;
    assign sd_cs_n  = cs_n_q;

endmodule

// File: doc/sd_spi_block.md
Name: sd_spi_block

Overview:
- Downstream consumer of the UART command slave's SD request interface: single-block SD read and write over SPI mode 0.
- Contains a 512-byte sector buffer. The UART side fills it byte by byte (write) or reads it after completion (read).
- The card is initialised elsewhere and is in SPI mode with CRC off. This block issues only CMD17 and CMD24.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period, minimum 1.
- BLOCK_ADDR, 1: 1 = card argument is lba (SDHC); 0 = argument is lba<<9 (byte address).
- TIMEOUT, 16'hFFFF: maximum polled bytes while waiting for the read token or for write busy to end.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- lba  in  32  sector address, sampled when an operation is accepted
- rd_req  in  1  single-cycle strobe: read sector lba into the buffer
- wr_req  in  1  store wr_data at buffer[wr_addr]; a store to address 511 also commits the buffer to sector lba
- wr_data  in  8  write byte
- wr_addr  in  9  write byte index
- rd_addr  in  9  buffer read index
- rd_data  out  8  buffer[rd_addr], registered, 1-cycle latency
- busy  out  1  an operation is in progress
- done  out  1  level: last operation succeeded; cleared when a new operation is accepted
- err  out  1  level: last operation failed; cleared when a new operation is accepted
- err_code  out  3  1 = R1 timeout, 2 = R1 nonzero, 3 = token timeout/error token, 4 = data response rejected, 5 = busy timeout
- sd_sclk  out  1  SPI clock, idles low
- sd_mosi  out  1  SPI data out, idles high
- sd_miso  in  1  SPI data in
- sd_cs_n  out  1  card select, active low

Behaviour:
- Reset (async, rst_n=0) values: busy=0, done=0, err=0, err_code=0, rd_data=0, sd_sclk=0, sd_mosi=1, sd_cs_n=1, FSM=IDLE.
- Reset mid-operation aborts immediately. Buffer contents become undefined.
- Acceptance, only in IDLE:
  - rd_req starts a read.
  - wr_req with wr_addr==511 stores the byte and starts a write.
  - On acceptance: lba latched, busy=1 on the next cycle, done=0, err=0.
- Requests and buffer stores while busy are ignored.
- If rd_req and a committing wr_req arrive in the same cycle, the read wins. The byte is still stored; the commit is dropped.
- Byte engine: MSB first, mode 0. MOSI changes on the SCLK falling edge (or at byte start); MISO is sampled on the rising edge. One byte takes 16*CLK_DIV clk cycles.
- Command frame, 6 bytes: 0x40|idx, arg[31:24..7:0], 0xFF.
  - idx = 17 for read, 24 for write.
  - arg = lba or lba<<9 (bits shifted out discarded).
- FSM states:
  - IDLE
  - CS_ON: sd_cs_n=0, send one 0xFF.
  - CMD: send 6 bytes.
  - R1: send 0xFF up to 8 times until MISO byte bit7=0. None found: error 1. Value nonzero: error 2.
  - Read path:
    - RD_TOK: poll 0xFF up to TIMEOUT bytes. 0xFE goes to RD_DATA. Any other non-0xFF value, or timeout: error 3.
    - RD_DATA: 512 bytes into buffer[0..511].
    - RD_CRC: 2 bytes, discarded.
  - Write path:
    - WR_GAP: one 0xFF.
    - WR_TOK: send 0xFE.
    - WR_DATA: buffer[0..511].
    - WR_CRC: 0xFF, 0xFF.
    - WR_RESP: next byte & 0x1F must equal 0x05, else error 4.
    - WR_BUSY: poll 0xFF until a nonzero byte arrives; more than TIMEOUT bytes: error 5.
  - FINISH: sd_cs_n=1, send one 0xFF, then IDLE.
    - Success: busy=0 and done=1 in the same cycle.
    - Any error path also passes through FINISH; it sets err=1 and err_code, with done=0.
- Counters: byte index 9 bits, wraps only by leaving its state. Timeout counter 16 bits, saturating compare.
- The buffer is a single-port-write, registered-read 512x8 array; the FSM and the host share the write port by busy.

Decomposition:
- Package sd_spi_pkg:
  - command constants CMD17=8'h51, CMD24=8'h58
  - tokens START_TOK=8'hFE, DATA_ACCEPT=5'h05
  - err_code localparams
  - FSM state encoding
- Sub-module sd_spi_byte:
  - ports: clk, rst_n, start, tx_byte[7:0], rx_byte[7:0], byte_done, sclk, mosi, miso; parameter CLK_DIV
  - sends one byte per start pulse; byte_done pulses for one cycle.
- sd_spi_block owns the FSM, buffer, counters and the cs_n line.

Test Plan:
- Read, with a card model returning R1=0x00 after 2 polls, 0xFE after 10, and data i^0x5A: lba=0x00001234, rd_req -> MOSI frame 51 00 00 12 34 FF; done=1, err=0; rd_addr=7 -> rd_data=0x5D one cycle later.
- Write, BLOCK_ADDR=0: store buffer[i]=i[7:0] for i=0..511 with lba=3 -> frame 58 00 00 06 00 FF, then FE, 512 data bytes, FF FF; model response 0xE5 plus 4 busy bytes of 0x00 -> done=1.
- Model never asserts R1 -> after 8 polls err=1, err_code=1, sd_cs_n=1, busy=0.
- Write data response 0x0B -> err=1, err_code=4, no busy polling, sd_cs_n=1.
- rd_req and wr_req at address 511 in the same cycle -> read frame 0x51 issued, no write; rd_req during busy ignored (exactly one frame seen).
- rst_n low in the middle of RD_DATA -> outputs return to reset values immediately; a later rd_req completes normally.
